// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: bus widths, stall vectors, exception
// codes and controller state encodings.
package pipe_ctrl_pkg;

    localparam int INST_ADDR_W = 32;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    localparam logic [INST_ADDR_W-1:0] ZERO_WORD = '0;

    localparam logic [3:0] EXC_ERET        = 4'hE;
    localparam logic [3:0] EXC_BUS_TIMEOUT = 4'h7;

    // Bit order: {wb, mem_wb, ex_mem, id_ex, if_id, pc}
    localparam logic [5:0] STALL_NONE = {NOSTOP, NOSTOP, NOSTOP, NOSTOP, NOSTOP, NOSTOP};
    localparam logic [5:0] STALL_ID   = {NOSTOP, NOSTOP, NOSTOP, STOP, STOP, STOP};
    localparam logic [5:0] STALL_EX   = {NOSTOP, NOSTOP, STOP, STOP, STOP, STOP};
    localparam logic [5:0] STALL_MEM  = {NOSTOP, STOP, STOP, STOP, STOP, STOP};

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } pipe_state_e;

    function automatic logic [INST_ADDR_W-1:0] exc_vector(
        input logic [INST_ADDR_W-1:0] base,
        input logic [3:0]             cause
    );
        return base + {23'b0, cause, 5'b0};
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stall/exception bus between the pipeline stages and the central controller.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic                   stallreq_id;
    logic                   stallreq_ex;
    logic                   stallreq_mem;
    logic                   except_valid;
    logic [3:0]             except_type;
    logic [INST_ADDR_W-1:0] epc_i;
    logic                   cnt_clr;
    logic [5:0]             stall;
    logic                   flush;
    logic [INST_ADDR_W-1:0] new_pc;
    logic                   timeout_o;
    logic [31:0]            stall_cnt;

    modport master (
        output stallreq_id, stallreq_ex, stallreq_mem,
        output except_valid, except_type, epc_i, cnt_clr,
        input  stall, flush, new_pc, timeout_o, stall_cnt
    );

    modport slave (
        input  stallreq_id, stallreq_ex, stallreq_mem,
        input  except_valid, except_type, epc_i, cnt_clr,
        output stall, flush, new_pc, timeout_o, stall_cnt
    );

endinterface

// File: rtl/pipe_ctrl_wdog.sv
// Memory-stall watchdog: counts consecutive RUN cycles with a data-bus wait
// and flags the cycle in which the wait reaches MEM_TIMEOUT.
module pipe_ctrl_wdog #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic stallreq_mem,
    input  logic clr,
    output logic fire
);

    logic [15:0] count;

    // The current cycle is the MEM_TIMEOUT-th consecutive waiting cycle.
    assign fire = active && stallreq_mem && (count == 16'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr || !active || !stallreq_mem) begin
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stall vector merge, exception/ERET flush
// sequencing with redirect PC, bus watchdog and stall-cycle counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int                     FLUSH_CYCLES = 1,
    parameter int                     MEM_TIMEOUT  = 255,
    parameter logic [INST_ADDR_W-1:0] EXC_BASE     = 32'h0000_0020
) (
    input  logic           clk,
    input  logic           rst_n,
    pipe_ctrl_if.slave     ctrl
);

    pipe_state_e            state, next_state;
    logic [3:0]             flush_cnt, next_flush_cnt;
    logic [INST_ADDR_W-1:0] new_pc_q, next_new_pc;
    logic                   timeout_q, next_timeout;
    logic [31:0]            stall_cnt_q;
    logic [5:0]             stall_vec;
    logic                   run;
    logic                   wdog_fire;
    logic                   enter_flush;

    assign run         = (state == ST_RUN);
    assign enter_flush = run && (ctrl.except_valid || wdog_fire);

    pipe_ctrl_wdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wdog (
        .clk          (clk),
        .rst_n        (rst_n),
        .active       (run),
        .stallreq_mem (ctrl.stallreq_mem),
        .clr          (enter_flush),
        .fire         (wdog_fire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            flush_cnt <= '0;
            new_pc_q  <= ZERO_WORD;
            timeout_q <= 1'b0;
        end else begin
            state     <= next_state;
            flush_cnt <= next_flush_cnt;
            new_pc_q  <= next_new_pc;
            timeout_q <= next_timeout;
        end
    end

    // An external exception outranks a coincident watchdog timeout.
    always_comb begin
        next_state     = state;
        next_flush_cnt = flush_cnt;
        next_new_pc    = new_pc_q;
        next_timeout   = 1'b0;
        case (state)
            ST_RUN: begin
                if (enter_flush) begin
                    next_state     = ST_FLUSH;
                    next_flush_cnt = '0;
                    if (ctrl.except_valid) begin
                        next_new_pc = (ctrl.except_type == EXC_ERET) ? ctrl.epc_i
                                    : exc_vector(EXC_BASE, ctrl.except_type);
                    end else begin
                        next_new_pc  = exc_vector(EXC_BASE, EXC_BUS_TIMEOUT);
                        next_timeout = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                if (flush_cnt == 4'(FLUSH_CYCLES - 1)) begin
                    next_state     = ST_RUN;
                    next_flush_cnt = '0;
                end else begin
                    next_flush_cnt = flush_cnt + 4'd1;
                end
            end
        endcase
    end

    // The deepest requesting stage wins; nothing stalls while flushing or in reset.
    always_comb begin
        stall_vec = STALL_NONE;
        if (rst_n && run) begin
            if (ctrl.stallreq_mem) begin
                stall_vec = STALL_MEM;
            end else if (ctrl.stallreq_ex) begin
                stall_vec = STALL_EX;
            end else if (ctrl.stallreq_id) begin
                stall_vec = STALL_ID;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (ctrl.cnt_clr) begin
            stall_cnt_q <= '0;
        end else if ((stall_vec != STALL_NONE) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign ctrl.stall     = stall_vec;
    assign ctrl.flush     = (state == ST_FLUSH);
    assign ctrl.new_pc    = new_pc_q;
    assign ctrl.timeout_o = timeout_q;
    assign ctrl.stall_cnt = stall_cnt_q;

endmodule
